// File: rtl/pch_bus_fabric.sv
// pch_bus_fabric: peripheral interconnect for the single-cycle RISC-V core.
// Decodes the CPU data address into NUM_SLV windows. It generates the select,
// write-enable and one-shot strobes, and muxes the slave read data back to the
// core. Slaves that are not ready stall the core. A watchdog bounds each stall,
// and bus errors are logged in a status register at ERR_ADDR.
module pch_bus_fabric #(
  parameter int                         NUM_SLV  = 8,
  parameter int                         ADDR_W   = 32,
  parameter int                         DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0]  SLV_MASK = '1,
  parameter int                         TIMEOUT  = 16,
  parameter logic [ADDR_W-1:0]          ERR_ADDR = 'h1001003C
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           HADDR,
  input  logic                        access,
  input  logic                        MemWrite,
  input  logic [DATA_W-1:0]           HWDATA_IN,
  input  logic [NUM_SLV*DATA_W-1:0]   HRDATA_IN,
  input  logic [NUM_SLV-1:0]          HREADY_IN,
  output logic [NUM_SLV-1:0]          sel,
  output logic [NUM_SLV-1:0]          wr_en,
  output logic [NUM_SLV-1:0]          wr_pulse,
  output logic [NUM_SLV-1:0]          rd_pulse,
  output logic [DATA_W-1:0]           HWDATA_OUT,
  output logic [DATA_W-1:0]           HRDATA_OUT,
  output logic                        stall,
  output logic                        bus_err
);

  localparam int         IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [7:0] TMO   = 8'(TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic              r_bus_err;
  logic [ADDR_W-1:0] r_err_addr;
  logic [15:0]       r_err_cnt;

  logic              w_act;
  logic              w_err_hit;
  logic              w_err_wr;
  logic              w_win_hit;
  logic [IDX_W-1:0]  w_idx;
  logic              w_slv_hit;
  logic              w_unmapped;
  logic              w_rdy;
  logic              w_complete;
  logic              w_timeout;
  logic              w_err_evt;
  logic              w_stall;
  logic              w_first;
  logic [NUM_SLV-1:0] w_sel;
  logic [31:0]       w_status;

  // Holding reset low blanks every strobe, even before the state is cleared.
  assign w_act      = access & reset;
  assign w_err_hit  = w_act && (HADDR == ERR_ADDR);
  assign w_err_wr   = w_err_hit && MemWrite;
  assign w_slv_hit  = w_act && !w_err_hit && w_win_hit;
  assign w_unmapped = w_act && !w_err_hit && !w_win_hit;
  assign w_rdy      = HREADY_IN[w_idx];
  assign w_complete = w_slv_hit && w_rdy;
  assign w_timeout  = (r_state == S_WAIT) && w_slv_hit && !w_rdy && (r_cnt == TMO);
  assign w_err_evt  = w_unmapped || w_timeout;
  assign w_status   = {r_err_cnt, 15'b0, r_bus_err};

  // Window decode: the lowest-index matching window wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    w_win_hit = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (!w_win_hit &&
          ((HADDR & SLV_MASK[k*ADDR_W +: ADDR_W]) ==
           (SLV_BASE[k*ADDR_W +: ADDR_W] & SLV_MASK[k*ADDR_W +: ADDR_W]))) begin
        w_win_hit = 1'b1;
        w_idx     = IDX_W'(k);
      end
    end
  end

  // One-hot select of the winning window.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      w_sel[k] = w_slv_hit && (w_idx == IDX_W'(k));
    end
  end

  // Next state, wait counter and stall. Strobes fire only from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_first     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_first = 1'b1;
        if (w_slv_hit && !w_rdy) begin
          w_stall     = 1'b1;
          w_cnt_nxt   = 8'd1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_slv_hit || w_rdy || (r_cnt == TMO)) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Data paths. A timed-out load returns 0 because w_rdy is low in that cycle.
  always_comb begin
    HRDATA_OUT = '0;
    if (!MemWrite) begin
      if (w_err_hit) begin
        HRDATA_OUT = DATA_W'(w_status);
      end else if (w_complete) begin
        HRDATA_OUT = HRDATA_IN[w_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign sel        = w_sel;
  assign wr_en      = w_sel & {NUM_SLV{MemWrite}};
  assign wr_pulse   = w_sel & {NUM_SLV{MemWrite & w_first}};
  assign rd_pulse   = w_sel & {NUM_SLV{~MemWrite & w_first}};
  assign HWDATA_OUT = ((|wr_en) || w_err_wr) ? HWDATA_IN : '0;
  assign stall      = w_stall;
  assign bus_err    = r_bus_err;

  // FSM state register and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: async active-low reset, and non-blocking assignments for all sequential state.
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sticky error log. A status store clears the flag and count but keeps the address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
      r_err_cnt  <= 16'd0;
    end else if (w_err_wr) begin
      r_bus_err <= 1'b0;
      r_err_cnt <= 16'd0;
    end else if (w_err_evt) begin
      r_bus_err  <= 1'b1;
      r_err_addr <= HADDR;
      if (r_err_cnt != 16'hFFFF) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pch_bus_fabric.sv
// Directed testbench for pch_bus_fabric, with hand-computed expectations.
module tb_pch_bus_fabric;

  localparam logic [255:0] BASE = {32'h1001_0000, 32'h1007_0000, 32'h1006_0000,
                                   32'h1005_0000, 32'h1004_0000, 32'h1003_0000,
                                   32'h1002_0000, 32'h1001_0024};
  localparam logic [255:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                   32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000,
                                   32'hFFFF_F000, 32'hFFFF_FFFF};
  localparam logic [31:0]  ERRA = 32'h1001_003C;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  HADDR;
  logic         access;
  logic         MemWrite;
  logic [31:0]  HWDATA_IN;
  logic [255:0] HRDATA_IN;
  logic [7:0]   HREADY_IN;
  logic [7:0]   sel, wr_en, wr_pulse, rd_pulse;
  logic [31:0]  HWDATA_OUT, HRDATA_OUT;
  logic         stall, bus_err;

  int n_vec = 0;
  int n_err = 0;

  pch_bus_fabric #(
    .NUM_SLV(8), .ADDR_W(32), .DATA_W(32),
    .SLV_BASE(BASE), .SLV_MASK(MASK),
    .TIMEOUT(16), .ERR_ADDR(ERRA)
  ) dut (
    .clk(clk), .reset(reset), .HADDR(HADDR), .access(access),
    .MemWrite(MemWrite), .HWDATA_IN(HWDATA_IN), .HRDATA_IN(HRDATA_IN),
    .HREADY_IN(HREADY_IN), .sel(sel), .wr_en(wr_en), .wr_pulse(wr_pulse),
    .rd_pulse(rd_pulse), .HWDATA_OUT(HWDATA_OUT), .HRDATA_OUT(HRDATA_OUT),
    .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic acc, input logic we, input logic [31:0] a, input logic [31:0] d);
    access    = acc;
    MemWrite  = we;
    HADDR     = a;
    HWDATA_IN = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    HREADY_IN = 8'hFF;
    bus(1'b1, 1'b0, 32'h1001_0024, 32'h0);
    #2;
    n_vec++; if (sel !== 8'h00) begin n_err++; $display("FAIL rst_sel: got %h want 00", sel); end
    n_vec++; if (rd_pulse !== 8'h00) begin n_err++; $display("FAIL rst_rd_pulse: got %h want 00", rd_pulse); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rst_bus_err: got %b want 0", bus_err); end
    n_vec++; if (HRDATA_OUT !== 32'h0) begin n_err++; $display("FAIL rst_hrdata: got %h want 0", HRDATA_OUT); end
    tick();
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_priority();
    bus(1'b1, 1'b0, 32'h1001_0024, 32'h0);
    #1;
    n_vec++; if (sel !== 8'h01) begin n_err++; $display("FAIL prio_sel: got %h want 01", sel); end
    n_vec++; if (rd_pulse !== 8'h01) begin n_err++; $display("FAIL prio_rd_pulse: got %h want 01", rd_pulse); end
    n_vec++; if (wr_pulse !== 8'h00) begin n_err++; $display("FAIL prio_wr_pulse: got %h want 00", wr_pulse); end
    n_vec++; if (HRDATA_OUT !== 32'hD000_0000) begin n_err++; $display("FAIL prio_hrdata: got %h want d0000000", HRDATA_OUT); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL prio_stall: got %b want 0", stall); end
    tick();
    bus(1'b1, 1'b0, 32'h1001_0028, 32'h0);
    #1;
    n_vec++; if (sel !== 8'h80) begin n_err++; $display("FAIL win7_sel: got %h want 80", sel); end
    n_vec++; if (HRDATA_OUT !== 32'hD000_0007) begin n_err++; $display("FAIL win7_hrdata: got %h want d0000007", HRDATA_OUT); end
    tick();
    bus(1'b0, 1'b0, 32'h1001_0028, 32'h0);
    #1;
    n_vec++; if (rd_pulse !== 8'h00) begin n_err++; $display("FAIL idle_rd_pulse: got %h want 00", rd_pulse); end
    n_vec++; if (HRDATA_OUT !== 32'h0) begin n_err++; $display("FAIL idle_hrdata: got %h want 0", HRDATA_OUT); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      bus(1'b1, 1'b0, 32'h1003_0004, 32'h0);
      #1;
      n_vec++; if (rd_pulse !== 8'h04) begin n_err++; $display("FAIL b2b_rd_pulse%0d: got %h want 04", i, rd_pulse); end
      n_vec++; if (HRDATA_OUT !== 32'hD000_0002) begin n_err++; $display("FAIL b2b_hrdata%0d: got %h want d0000002", i, HRDATA_OUT); end
      tick();
    end
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_wait_states();
    HREADY_IN = 8'hFB;
    bus(1'b1, 1'b0, 32'h1003_0004, 32'h0);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL ws_stall1: got %b want 1", stall); end
    n_vec++; if (rd_pulse !== 8'h04) begin n_err++; $display("FAIL ws_rd_pulse1: got %h want 04", rd_pulse); end
    tick();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL ws_stall2: got %b want 1", stall); end
    n_vec++; if (rd_pulse !== 8'h00) begin n_err++; $display("FAIL ws_rd_pulse2: got %h want 00", rd_pulse); end
    n_vec++; if (sel !== 8'h04) begin n_err++; $display("FAIL ws_sel2: got %h want 04", sel); end
    tick();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL ws_stall3: got %b want 1", stall); end
    tick();
    HREADY_IN = 8'hFF;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ws_stall4: got %b want 0", stall); end
    n_vec++; if (HRDATA_OUT !== 32'hD000_0002) begin n_err++; $display("FAIL ws_hrdata4: got %h want d0000002", HRDATA_OUT); end
    n_vec++; if (rd_pulse !== 8'h00) begin n_err++; $display("FAIL ws_rd_pulse4: got %h want 00", rd_pulse); end
    tick();
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL ws_bus_err: got %b want 0", bus_err); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    HREADY_IN = 8'hFD;
    bus(1'b1, 1'b1, 32'h1002_0010, 32'h0000_00A5);
    #1;
    n_vec++; if (wr_pulse !== 8'h02) begin n_err++; $display("FAIL to_wr_pulse: got %h want 02", wr_pulse); end
    n_vec++; if (HWDATA_OUT !== 32'hA5) begin n_err++; $display("FAIL to_hwdata: got %h want a5", HWDATA_OUT); end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!stall) break;
      n++;
      @(posedge clk);
      #2;
    end
    n_vec++; if (n !== 16) begin n_err++; $display("FAIL to_stall_cycles: got %0d want 16", n); end
    n_vec++; if (wr_en !== 8'h02) begin n_err++; $display("FAIL to_wr_en: got %h want 02", wr_en); end
    n_vec++; if (wr_pulse !== 8'h00) begin n_err++; $display("FAIL to_wr_pulse_end: got %h want 00", wr_pulse); end
    tick();
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    HREADY_IN = 8'hFF;
    #1;
    n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_bus_err: got %b want 1", bus_err); end
    n_vec++; if (dut.r_err_addr !== 32'h1002_0010) begin n_err++; $display("FAIL to_err_addr: got %h want 10020010", dut.r_err_addr); end
    tick();
    bus(1'b1, 1'b0, ERRA, 32'h0);
    #1;
    n_vec++; if (HRDATA_OUT !== 32'h0001_0001) begin n_err++; $display("FAIL to_status: got %h want 00010001", HRDATA_OUT); end
    n_vec++; if (sel !== 8'h00) begin n_err++; $display("FAIL status_sel: got %h want 00", sel); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL status_stall: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_unmapped_status();
    bus(1'b1, 1'b0, 32'h2000_0000, 32'h0);
    #1;
    n_vec++; if (HRDATA_OUT !== 32'h0) begin n_err++; $display("FAIL um_hrdata: got %h want 0", HRDATA_OUT); end
    n_vec++; if (sel !== 8'h00) begin n_err++; $display("FAIL um_sel: got %h want 00", sel); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL um_stall: got %b want 0", stall); end
    tick();
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL um_bus_err: got %b want 1", bus_err); end
    n_vec++; if (dut.r_err_addr !== 32'h2000_0000) begin n_err++; $display("FAIL um_err_addr: got %h want 20000000", dut.r_err_addr); end
    tick();
    bus(1'b1, 1'b0, ERRA, 32'h0);
    #1;
    n_vec++; if (HRDATA_OUT !== 32'h0002_0001) begin n_err++; $display("FAIL um_status: got %h want 00020001", HRDATA_OUT); end
    tick();
    bus(1'b1, 1'b1, ERRA, 32'h0000_1234);
    #1;
    n_vec++; if (HWDATA_OUT !== 32'h1234) begin n_err++; $display("FAIL clr_hwdata: got %h want 1234", HWDATA_OUT); end
    n_vec++; if (wr_en !== 8'h00) begin n_err++; $display("FAIL clr_wr_en: got %h want 00", wr_en); end
    tick();
    bus(1'b1, 1'b0, ERRA, 32'h0);
    #1;
    n_vec++; if (HRDATA_OUT !== 32'h0) begin n_err++; $display("FAIL clr_status: got %h want 0", HRDATA_OUT); end
    n_vec++; if (dut.r_err_addr !== 32'h2000_0000) begin n_err++; $display("FAIL clr_err_addr: got %h want 20000000", dut.r_err_addr); end
    tick();
    bus(1'b1, 1'b1, 32'h2000_0000, 32'h0000_00FF);
    #1;
    n_vec++; if (HWDATA_OUT !== 32'h0) begin n_err++; $display("FAIL um_st_hwdata: got %h want 0", HWDATA_OUT); end
    n_vec++; if (wr_en !== 8'h00) begin n_err++; $display("FAIL um_st_wr_en: got %h want 00", wr_en); end
    tick();
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid_wait();
    n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL rmw_pre_bus_err: got %b want 1", bus_err); end
    HREADY_IN = 8'hF7;
    bus(1'b1, 1'b0, 32'h1004_0000, 32'h0);
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rmw_stall_pre: got %b want 1", stall); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rmw_stall: got %b want 0", stall); end
    n_vec++; if (sel !== 8'h00) begin n_err++; $display("FAIL rmw_sel: got %h want 00", sel); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rmw_bus_err: got %b want 0", bus_err); end
    n_vec++; if (dut.r_state !== 1'b0) begin n_err++; $display("FAIL rmw_state: got %b want 0", dut.r_state); end
    tick();
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    HREADY_IN = 8'hFF;
    reset = 1'b1;
    tick();
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rmw_post_bus_err: got %b want 0", bus_err); end
    bus(1'b1, 1'b0, ERRA, 32'h0);
    #1;
    n_vec++; if (HRDATA_OUT !== 32'h0) begin n_err++; $display("FAIL rmw_status: got %h want 0", HRDATA_OUT); end
    n_vec++; if (dut.r_err_addr !== 32'h0) begin n_err++; $display("FAIL rmw_err_addr: got %h want 0", dut.r_err_addr); end
    tick();
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) HRDATA_IN[k*32 +: 32] = 32'hD000_0000 + k;
    test_reset();
    test_priority();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_unmapped_status();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pch_bus_fabric.md
Name: pch_bus_fabric

Overview:
- Parametrised peripheral interconnect for the single-cycle RISC-V core.
- Decodes the CPU data address into NUM_SLV configurable address windows and generates per-slave select, write-enable and one-shot read/write pulses (used, for example, for UART RX read-to-clear and TX send).
- Muxes slave read data back to the core.
- Adds features the previous fixed decoder lacked: slave wait states with a core stall, a timeout watchdog, and a sticky bus-error status register at ERR_ADDR.

Parameters:
- NUM_SLV, 8, number of slave windows (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- SLV_BASE, packed NUM_SLV*ADDR_W, base address of window k in bits [k*ADDR_W +: ADDR_W].
- SLV_MASK, packed NUM_SLV*ADDR_W, compare mask of window k. Window k hits when (HADDR & mask) == (base & mask).
- TIMEOUT, 16, maximum stall cycles before a forced error completion (2..255).
- ERR_ADDR, 'h1001003C, address of the internal error status register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- HADDR  in  ADDR_W  CPU data address.
- access  in  1  CPU performs a load or store this cycle.
- MemWrite  in  1  1 = store, 0 = load (valid when access=1).
- HWDATA_IN  in  DATA_W  store data from the CPU.
- HRDATA_IN  in  NUM_SLV*DATA_W  read data of slave k at [k*DATA_W +: DATA_W].
- HREADY_IN  in  NUM_SLV  slave k can complete the access this cycle.
- sel  out  NUM_SLV  one-hot select of the hit window.
- wr_en  out  NUM_SLV  sel & MemWrite, level signal.
- wr_pulse  out  NUM_SLV  one-cycle store strobe.
- rd_pulse  out  NUM_SLV  one-cycle load strobe.
- HWDATA_OUT  out  DATA_W  store data; 0 when not storing.
- HRDATA_OUT  out  DATA_W  load data to the CPU.
- stall  out  1  freeze the CPU (PC and register-file write).
- bus_err  out  1  sticky error flag.

Behaviour:
- Decode (combinational)
  - ERR_ADDR has the highest priority; it is an internal hit, so no sel bit is asserted.
  - Otherwise the lowest-index matching window wins, and exactly one sel bit is set.
  - No match while access=1 is an unmapped access.
  - All of sel, wr_en and the pulses are 0 when access=0 or reset=0.
- FSM states: IDLE, WAIT. Registers: state, cnt[7:0], bus_err, err_addr[ADDR_W], err_cnt[15:0].
- IDLE, access to slave k:
  - Pulses: rd_pulse[k] or wr_pulse[k] asserted this cycle only.
  - If HREADY_IN[k]=1: stall=0, HRDATA_OUT = slave k data (loads), access completes, stay in IDLE.
  - If HREADY_IN[k]=0: stall=1, cnt<=1, go to WAIT.
- WAIT:
  - sel and wr_en are held; pulses are 0.
  - If HREADY_IN[k]=1: stall=0, data returned, go to IDLE.
  - Else if cnt==TIMEOUT: stall=0, HRDATA_OUT=0, store discarded (wr_en still asserted that cycle; slaves must sample only on ready). Error event raised; go to IDLE.
  - Else stall=1, cnt++.
  - If access drops in WAIT: go to IDLE, no error.
- Back-to-back completed accesses to the same address each produce a new pulse, because every completion returns to IDLE.
- Unmapped access:
  - stall=0, HRDATA_OUT=0, no slave write.
  - Error event raised.
- Error event (unmapped or timeout), on the next edge:
  - bus_err<=1.
  - err_addr<=HADDR.
  - err_cnt<=err_cnt+1, saturating at 'hFFFF.
- ERR_ADDR access, always completes with stall=0:
  - Load returns {err_cnt, 15'b0, bus_err} (LSB-aligned when DATA_W=32).
  - Store of any value clears bus_err and err_cnt; err_addr is retained.
  - An error event cannot coincide with an ERR_ADDR access (they need different addresses), so no conflict arises.
- HRDATA_OUT is 0 on stores and when idle.
- HWDATA_OUT = HWDATA_IN when wr_en is nonzero or on an ERR_ADDR store, else 0.
- Reset (asynchronous, active-low):
  - state=IDLE, cnt=0, bus_err=0, err_addr=0, err_cnt=0.
  - stall=0, all strobes 0.
  - Reset asserted mid-WAIT aborts the access immediately, with no error logged.

Test Plan:
- Windows 0 ('h10010024, mask all-ones) and 7 ('h10010000, mask 'hFFFF0000); load 'h10010024 with HREADY_IN all 1 -> sel=8'h01 (lowest index wins), rd_pulse[0] high for 1 cycle, HRDATA_OUT = slave0 data, stall=0.
- Two consecutive loads to RX window 2 -> rd_pulse[2] high in both cycles; one load with HREADY_IN[2] low for 3 cycles -> stall high 3 cycles, rd_pulse[2] only in the first cycle, data returned in cycle 4.
- Store 'hA5 to window 1 with HREADY_IN[1]=0 held, TIMEOUT=16 -> stall high 16 cycles then 0, bus_err=1, err_cnt=1, err_addr = window 1 address.
- Load unmapped 'h20000000 -> stall=0, HRDATA_OUT=0, sel=0, bus_err=1 next cycle; load ERR_ADDR -> 'h00010001 (err_cnt=1, bus_err=1); store to ERR_ADDR -> next read 'h00000000.
- Assert reset mid-WAIT -> stall=0, state IDLE, bus_err=0 immediately, no error logged after release.
